// File: rtl/fat32_arb_pkg.sv
// Shared types and widths for the FAT32 request arbiter.
// Build option FAT32_ARB_PRIORITY_EN selects fixed-priority arbitration instead of round-robin.
package fat32_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int FILENAME_W = 64;
    localparam int EXT_W      = 24;
    localparam int SIZE_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUN,
        DONE
    } arb_state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fat32_arb_pick.sv
// Winner selection for the FAT32 arbiter: one-hot winner from the request vector.
// FAT32_ARB_PRIORITY_EN defined: lowest slot always wins; otherwise round-robin after last_gnt.
module fat32_arb_pick
    import fat32_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] winner
);

`ifdef FAT32_ARB_PRIORITY_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = NUM_REQ'(1) << i;
        end
    end
`else
    // Search starts at the slot just after the last one served and wraps.
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_gnt) + k) % NUM_REQ;
            if (winner == '0 && req[idx]) winner[idx] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/fat32_arbiter.sv
// Two-requester arbiter in front of a single FAT32 controller; one transaction at a time.
// Build option FAT32_ARB_PRIORITY_EN switches winner selection to fixed priority (slot 0 first).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no grant; arbitrate and capture winner's parameters
// LAUNCH    | f_execute high for this single cycle
// WAIT_BUSY | waiting for controller to raise f_busy, bounded by timeout
// RUN       | controller busy; strobes steered to granted slot
// DONE      | done (and err on timeout) pulse, grant released
module fat32_arbiter
    import fat32_arb_pkg::*;
#(
    parameter int BUSY_WAIT_MAX = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,

    input  logic [NUM_REQ*FILENAME_W-1:0] req_filename,
    input  logic [NUM_REQ*EXT_W-1:0]      req_extension,
    input  logic [NUM_REQ*SIZE_W-1:0]     req_file_size,
    input  logic [NUM_REQ-1:0]            req_op_code,
    input  logic [NUM_REQ*BYTE_W-1:0]     req_outgoing_byte,

    output logic [BYTE_W-1:0]             rsp_incoming_byte,
    output logic [NUM_REQ-1:0]            rsp_finished_byte,
    output logic [NUM_REQ-1:0]            rsp_finished_block,

    output logic [FILENAME_W-1:0]         f_filename,
    output logic [EXT_W-1:0]              f_extension,
    output logic [SIZE_W-1:0]             f_file_size,
    output logic                          f_op_code,
    output logic                          f_execute,
    output logic [BYTE_W-1:0]             f_outgoing_byte,
    input  logic [BYTE_W-1:0]             f_incoming_byte,
    input  logic                          f_finished_byte,
    input  logic                          f_finished_block,
    input  logic                          f_busy
);

    localparam int                CNT_W     = $clog2(BUSY_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(BUSY_WAIT_MAX - 1);

    arb_state_e           state_q;
    arb_state_e           state_d;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   winner;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     last_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 timeout_q;
    logic                 busy_expired;

    fat32_arb_pick u_pick (
        .req      (req),
        .last_gnt (last_q),
        .winner   (winner)
    );

    assign win_idx      = onehot_to_idx(winner);
    assign busy_expired = (cnt_q == CNT_LIMIT) && !f_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        f_execute = 1'b0;
        case (state_q)
            IDLE:      if (|req) state_d = LAUNCH;
            LAUNCH: begin
                f_execute = 1'b1;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (f_busy)            state_d = RUN;
                else if (busy_expired) state_d = DONE;
            end
            RUN:       if (!f_busy) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Grant, pointer, timeout counter and the controller parameter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            f_filename  <= '0;
            f_extension <= '0;
            f_file_size <= '0;
            f_op_code   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q       <= winner;
                        timeout_q   <= 1'b0;
                        f_filename  <= req_filename[int'(win_idx)*FILENAME_W +: FILENAME_W];
                        f_extension <= req_extension[int'(win_idx)*EXT_W +: EXT_W];
                        f_file_size <= req_file_size[int'(win_idx)*SIZE_W +: SIZE_W];
                        f_op_code   <= req_op_code[win_idx];
                    end
                end
                LAUNCH: cnt_q <= '0;
                WAIT_BUSY: begin
                    if (!f_busy) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (busy_expired) timeout_q <= 1'b1;
                    end
                end
                DONE: begin
                    last_q <= onehot_to_idx(gnt_q);
                    gnt_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = (state_q == DONE) ? gnt_q : '0;
    assign err  = (state_q == DONE && timeout_q) ? gnt_q : '0;

    always_comb begin
        f_outgoing_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) f_outgoing_byte = f_outgoing_byte | req_outgoing_byte[i*BYTE_W +: BYTE_W];
        end
    end

    assign rsp_incoming_byte  = f_incoming_byte;
    assign rsp_finished_byte  = gnt_q & {NUM_REQ{f_finished_byte}};
    assign rsp_finished_block = gnt_q & {NUM_REQ{f_finished_block}};

endmodule

// File: tb/tb_fat32_arbiter.sv
// Self-checking bench for fat32_arbiter: expected grant slots are queued as requests are
// driven and popped when the arbiter launches/completes the corresponding transaction.
module tb_fat32_arbiter;

    localparam int BWM = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    gnt, done, err;
    logic [127:0]  req_filename;
    logic [47:0]   req_extension;
    logic [63:0]   req_file_size;
    logic [1:0]    req_op_code;
    logic [15:0]   req_outgoing_byte;
    logic [7:0]    rsp_incoming_byte;
    logic [1:0]    rsp_finished_byte, rsp_finished_block;
    logic [63:0]   f_filename;
    logic [23:0]   f_extension;
    logic [31:0]   f_file_size;
    logic          f_op_code, f_execute;
    logic [7:0]    f_outgoing_byte, f_incoming_byte;
    logic          f_finished_byte, f_finished_block, f_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    logic [63:0] fn0 = "rom     ";
    logic [63:0] fn1 = "data    ";

    fat32_arbiter #(.BUSY_WAIT_MAX(BWM)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .gnt                (gnt),
        .done               (done),
        .err                (err),
        .req_filename       (req_filename),
        .req_extension      (req_extension),
        .req_file_size      (req_file_size),
        .req_op_code        (req_op_code),
        .req_outgoing_byte  (req_outgoing_byte),
        .rsp_incoming_byte  (rsp_incoming_byte),
        .rsp_finished_byte  (rsp_finished_byte),
        .rsp_finished_block (rsp_finished_block),
        .f_filename         (f_filename),
        .f_extension        (f_extension),
        .f_file_size        (f_file_size),
        .f_op_code          (f_op_code),
        .f_execute          (f_execute),
        .f_outgoing_byte    (f_outgoing_byte),
        .f_incoming_byte    (f_incoming_byte),
        .f_finished_byte    (f_finished_byte),
        .f_finished_block   (f_finished_block),
        .f_busy             (f_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] exp_gnt(input int slot);
        return (slot == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [63:0] exp_fn(input int slot);
        return (slot == 1) ? fn1 : fn0;
    endfunction

    function automatic logic [7:0] exp_ob(input int slot);
        return (slot == 1) ? 8'hB1 : 8'hA0;
    endfunction

    function automatic logic [31:0] exp_size(input int slot);
        return (slot == 1) ? 32'h00AB_CDEF : 32'h0000_1234;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = 2'b00;
        f_busy = 1'b0;
        f_finished_byte = 1'b0;
        f_finished_block = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits for the launch, checks it against the queued slot, runs the controller handshake.
    task automatic run_txn(input string name, input int busy_delay, input int busy_len,
                           output int lat);
        bit seen;
        int slot;
        int n;
        int extra_exec;
        seen = 0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            lat++;
            if (f_execute === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_exec: no f_execute within 20 cycles", name);
            return;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb: launch observed with empty scoreboard", name);
            return;
        end
        slot = exp_q.pop_front();
        n_checks++;
        if (gnt !== exp_gnt(slot)) begin
            n_fail++;
            $display("FAIL %s_gnt: got %b expected %b", name, gnt, exp_gnt(slot));
        end
        n_checks++;
        if (f_filename !== exp_fn(slot) || f_file_size !== exp_size(slot) ||
            f_op_code !== slot[0]) begin
            n_fail++;
            $display("FAIL %s_params: got %h/%h/%b expected %h/%h/%b", name, f_filename,
                     f_file_size, f_op_code, exp_fn(slot), exp_size(slot), slot[0]);
        end
        n_checks++;
        if (f_outgoing_byte !== exp_ob(slot)) begin
            n_fail++;
            $display("FAIL %s_outbyte: got %h expected %h", name, f_outgoing_byte, exp_ob(slot));
        end
        extra_exec = 0;
        repeat (busy_delay) begin
            tick();
            if (f_execute !== 1'b0 || done !== 2'b00) extra_exec++;
        end
        f_busy = 1'b1;
        repeat (busy_len) begin
            tick();
            if (f_execute !== 1'b0 || done !== 2'b00) extra_exec++;
        end
        f_busy = 1'b0;
        n = 0;
        while (n < 10 && done === 2'b00) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL %s_done_lat: got %0d cycles expected 1", name, n);
        end
        n_checks++;
        if (done !== exp_gnt(slot) || err !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_done: got done=%b err=%b expected done=%b err=00", name, done, err,
                     exp_gnt(slot));
        end
        n_checks++;
        if (f_filename !== exp_fn(slot)) begin
            n_fail++;
            $display("FAIL %s_hold: got %h expected %h", name, f_filename, exp_fn(slot));
        end
        n_checks++;
        if (extra_exec !== 0) begin
            n_fail++;
            $display("FAIL %s_spurious: got %0d stray execute/done cycles expected 0", name,
                     extra_exec);
        end
        tick();
        n_checks++;
        if (done !== 2'b00 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_release: got done=%b gnt=%b expected 00/00", name, done, gnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b11;
        f_busy = 1'b0;
        f_finished_byte = 1'b1;
        f_finished_block = 1'b1;
        #3;
        n_checks++;
        if ({gnt, done, err, f_execute} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got gnt=%b done=%b err=%b exec=%b expected zeros",
                     gnt, done, err, f_execute);
        end
        n_checks++;
        if ({f_filename, f_extension, f_file_size, f_op_code} !== 121'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h %h %h %b expected zeros", f_filename,
                     f_extension, f_file_size, f_op_code);
        end
        n_checks++;
        if ({f_outgoing_byte, rsp_finished_byte, rsp_finished_block} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_steer: got %h %b %b expected zeros", f_outgoing_byte,
                     rsp_finished_byte, rsp_finished_block);
        end
        repeat (2) tick();
        n_checks++;
        if (gnt !== 2'b00 || f_execute !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got gnt=%b exec=%b expected 00/0", gnt, f_execute);
        end
        apply_reset();
    endtask

    task automatic test_single();
        int lat;
        apply_reset();
        req = 2'b01;
        exp_q.push_back(0);
        run_txn("single", 2, 10, lat);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d expected 1", lat);
        end
        req = 2'b00;
    endtask

    task automatic test_round_robin();
        int lat;
        apply_reset();
        req = 2'b11;
`ifdef FAT32_ARB_PRIORITY_EN
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
`else
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
`endif
        for (int t = 0; t < 3; t++) run_txn($sformatf("rr%0d", t), 1, 3 + t, lat);
        req = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        apply_reset();
        req = 2'b01;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (f_execute === 1'b1) seen = 1;
        end
        req = 2'b00;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout_exec: no f_execute within 20 cycles");
            return;
        end
        n = 0;
        while (n < 40 && done === 2'b00) begin
            tick();
            n++;
            if (err !== 2'b00 && done === 2'b00) n = 100;
        end
        n_checks++;
        if (n !== BWM + 1) begin
            n_fail++;
            $display("FAIL timeout_lat: got %0d cycles from launch expected %0d", n, BWM + 1);
        end
        n_checks++;
        if (done !== 2'b01 || err !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_pulse: got done=%b err=%b expected 01/01", done, err);
        end
        tick();
        n_checks++;
        if (done !== 2'b00 || err !== 2'b00 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_clear: got done=%b err=%b gnt=%b expected zeros", done, err, gnt);
        end
    endtask

    task automatic test_steer();
        bit seen;
        int bad;
        int n;
        apply_reset();
        req = 2'b10;
        exp_q.push_back(1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (f_execute === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || gnt !== exp_gnt(exp_q[0])) begin
            n_fail++;
            $display("FAIL steer_gnt: got exec_seen=%0d gnt=%b expected 1/10", seen, gnt);
        end
        void'(exp_q.pop_front());
        f_busy = 1'b1;
        tick();
        req = 2'b01;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            f_finished_byte  = 1'($urandom_range(0, 1));
            f_finished_block = 1'($urandom_range(0, 1));
            f_incoming_byte  = 8'($urandom_range(0, 255));
            #1;
            if (rsp_finished_byte !== {f_finished_byte, 1'b0} ||
                rsp_finished_block !== {f_finished_block, 1'b0} ||
                rsp_incoming_byte !== f_incoming_byte ||
                f_outgoing_byte !== 8'hB1 || gnt !== 2'b10) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL steer_mirror: got %0d mismatching cycles expected 0", bad);
        end
        req = 2'b00;
        f_finished_byte = 1'b0;
        f_finished_block = 1'b0;
        f_busy = 1'b0;
        n = 0;
        while (n < 10 && done === 2'b00) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 1 || done !== 2'b10) begin
            n_fail++;
            $display("FAIL steer_done: got done=%b after %0d cycles expected 10 after 1", done, n);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        int bad;
        int lat;
        apply_reset();
        req = 2'b01;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (f_execute === 1'b1) seen = 1;
        end
        f_busy = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (!seen || gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_setup: got exec_seen=%0d gnt=%b expected 1/01", seen, gnt);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, done, err, f_execute} !== 7'b0 || f_filename !== 64'b0 ||
            f_outgoing_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async: got gnt=%b done=%b err=%b exec=%b fn=%h expected zeros",
                     gnt, done, err, f_execute, f_filename);
        end
        req = 2'b00;
        f_busy = 1'b0;
        bad = 0;
        repeat (2) begin
            tick();
            if (done !== 2'b00 || f_execute !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            if (done !== 2'b00 || f_execute !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midrst_quiet: got %0d cycles with done/execute expected 0", bad);
        end
        req = 2'b11;
        exp_q.push_back(0);
        run_txn("midrst_next", 2, 3, lat);
        req = 2'b00;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        req_filename = {fn1, fn0};
        req_extension = {"txt", "bin"};
        req_file_size = {32'h00AB_CDEF, 32'h0000_1234};
        req_op_code = 2'b10;
        req_outgoing_byte = {8'hB1, 8'hA0};
        f_incoming_byte = 8'h00;
        f_finished_byte = 1'b0;
        f_finished_block = 1'b0;
        f_busy = 1'b0;

        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_steer();
        test_reset_mid();

        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
